exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 211 +++++++++++++++++++++
 tb/tb_exe_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: ALU, iterative restoring divider, data-SRAM request generation
// and forwarding information for the decode stage.
module exe_stage #(
  parameter int DIV_EN   = 1,
  parameter int ALU_OP_W = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic                      exe_allowin,
  input  logic                      id_exe_valid,
  input  logic [173+ALU_OP_W-1:0]   id_exe_bus,
  input  logic                      exe_flush,
  output logic                      exe_mem_valid,
  input  logic                      mem_allowin,
  output logic [106:0]              exe_mem_bus,
  output logic                      data_sram_en,
  output logic [3:0]                data_sram_we,
  output logic [31:0]               data_sram_addr,
  output logic [31:0]               data_sram_wdata,
  output logic                      fwd_valid,
  output logic [4:0]                fwd_dest,
  output logic [31:0]               fwd_data,
  output logic                      fwd_stall
);

  localparam int OPN = (ALU_OP_W < 12) ? ALU_OP_W : 12;

  typedef struct packed {
    logic                gr_we;
    logic                mem_we;
    logic                res_from_mem;
    logic [1:0]          mem_size;
    logic [2:0]          md_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [4:0]          dest;
    logic [31:0]         rkd;
    logic [31:0]         inst;
    logic [31:0]         pc;
  } payload_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  payload_t   payload_q, payload_d;
  logic       exe_valid_q, exe_valid_d;
  div_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;

  logic        ready_go;
  logic        handoff;
  logic [2:0]  md_eff;
  logic        md_active;
  logic        md_signed;
  logic        md_is_mod;
  logic        s1_neg, s2_neg;
  logic [31:0] s1_abs, s2_abs;
  logic [32:0] trial;
  logic [31:0] div_result;
  logic [11:0] op;
  logic [31:0] alu_result;
  logic [31:0] result;
  logic [3:0]  lane_mask;

  // Payload is intentionally left unreset; nothing observes it while exe_valid is low.
  always_comb begin
    payload_d = payload_q;
    if (id_exe_valid && exe_allowin) payload_d = payload_t'(id_exe_bus);
  end

  always_ff @(posedge clk) payload_q <= payload_d;

  always_comb begin
    exe_valid_d = exe_valid_q;
    if (exe_flush)        exe_valid_d = 1'b0;
    else if (exe_allowin) exe_valid_d = id_exe_valid;
  end

  // Unused / out-of-range md_op codes behave exactly like a plain ALU op.
  always_comb begin
    md_eff = 3'd0;
    if (DIV_EN != 0 && payload_q.md_op >= 3'd1 && payload_q.md_op <= 3'd4) md_eff = payload_q.md_op;
  end

  assign md_active = (md_eff != 3'd0);
  assign md_signed = (md_eff == 3'd1) || (md_eff == 3'd2);
  assign md_is_mod = (md_eff == 3'd2) || (md_eff == 3'd4);
  assign s1_neg    = md_signed & payload_q.src1[31];
  assign s2_neg    = md_signed & payload_q.src2[31];
  assign s1_abs    = s1_neg ? (32'd0 - payload_q.src1) : payload_q.src1;
  assign s2_abs    = s2_neg ? (32'd0 - payload_q.src2) : payload_q.src2;
  assign trial     = {rem_q, quo_q[31]} - {1'b0, dvs_q};

  assign ready_go      = !md_active || (state_q == DIV_DONE);
  assign exe_mem_valid = exe_valid_q & ready_go & ~exe_flush;
  assign handoff       = exe_mem_valid & mem_allowin;
  assign exe_allowin   = ~exe_valid_q | (ready_go & mem_allowin);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    case (state_q)
      DIV_IDLE: begin
        if (exe_valid_q && md_active && !exe_flush) begin
          state_d = DIV_BUSY;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quo_d   = s1_abs;
          dvs_d   = s2_abs;
        end
      end
      DIV_BUSY: begin
        if (exe_flush) begin
          state_d = DIV_IDLE;
          cnt_d   = 5'd0;
        end else begin
          // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
          rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
          quo_d = {quo_q[30:0], ~trial[32]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (exe_flush || handoff) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      state_q     <= DIV_IDLE;
      cnt_q       <= 5'd0;
    end else begin
      exe_valid_q <= exe_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  // Division by zero bypasses sign fix-up so the quotient stays all ones.
  always_comb begin
    if (payload_q.src2 == 32'd0)
      div_result = md_is_mod ? payload_q.src1 : 32'hFFFF_FFFF;
    else if (md_is_mod)
      div_result = s1_neg ? (32'd0 - rem_q) : rem_q;
    else
      div_result = (s1_neg ^ s2_neg) ? (32'd0 - quo_q) : quo_q;
  end

  // One-hot ALU: add sub slt sltu and nor or xor sll srl sra lui.
  always_comb begin
    op = 12'd0;
    for (int i = 0; i < OPN; i++) op[i] = payload_q.alu_op[i];
  end

  always_comb begin
    alu_result = 32'd0;
    if (op[0])  alu_result = alu_result | (payload_q.src1 + payload_q.src2);
    if (op[1])  alu_result = alu_result | (payload_q.src1 - payload_q.src2);
    if (op[2])  alu_result = alu_result | {31'd0, $signed(payload_q.src1) < $signed(payload_q.src2)};
    if (op[3])  alu_result = alu_result | {31'd0, payload_q.src1 < payload_q.src2};
    if (op[4])  alu_result = alu_result | (payload_q.src1 & payload_q.src2);
    if (op[5])  alu_result = alu_result | ~(payload_q.src1 | payload_q.src2);
    if (op[6])  alu_result = alu_result | (payload_q.src1 | payload_q.src2);
    if (op[7])  alu_result = alu_result | (payload_q.src1 ^ payload_q.src2);
    if (op[8])  alu_result = alu_result | (payload_q.src1 << payload_q.src2[4:0]);
    if (op[9])  alu_result = alu_result | (payload_q.src1 >> payload_q.src2[4:0]);
    if (op[10]) alu_result = alu_result | 32'($signed(payload_q.src1) >>> payload_q.src2[4:0]);
    if (op[11]) alu_result = alu_result | payload_q.src2;
  end

  assign result = md_active ? div_result : alu_result;

  always_comb begin
    case (payload_q.mem_size)
      2'd0:    lane_mask = 4'b0001 << alu_result[1:0];
      2'd1:    lane_mask = alu_result[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    case (payload_q.mem_size)
      2'd0:    data_sram_wdata = {4{payload_q.rkd[7:0]}};
      2'd1:    data_sram_wdata = {2{payload_q.rkd[15:0]}};
      default: data_sram_wdata = payload_q.rkd;
    endcase
  end

  assign data_sram_en   = handoff & (payload_q.mem_we | payload_q.res_from_mem);
  assign data_sram_we   = (data_sram_en & payload_q.mem_we) ? lane_mask : 4'b0000;
  assign data_sram_addr = alu_result;

  assign exe_mem_bus = {payload_q.gr_we, payload_q.res_from_mem, payload_q.mem_size,
                        alu_result[1:0], payload_q.dest, payload_q.pc, payload_q.inst, result};

  assign fwd_valid = exe_valid_q & payload_q.gr_we & (payload_q.dest != 5'd0);
  assign fwd_dest  = payload_q.dest;
  assign fwd_data  = result;
  assign fwd_stall = exe_valid_q & payload_q.gr_we & (payload_q.res_from_mem | ~ready_go);

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: stores, loads, ALU forwarding, divides and flushes.
module tb_exe_stage;

  localparam int ALU_OP_W = 12;
  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_SUB = 12'h002;

  logic                    clk;
  logic                    resetn;
  logic                    exe_allowin;
  logic                    id_exe_valid;
  logic [173+ALU_OP_W-1:0] id_exe_bus;
  logic                    exe_flush;
  logic                    exe_mem_valid;
  logic                    mem_allowin;
  logic [106:0]            exe_mem_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_we;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    fwd_valid;
  logic [4:0]              fwd_dest;
  logic [31:0]             fwd_data;
  logic                    fwd_stall;

  int n_checks = 0;
  int n_errors = 0;

  exe_stage #(.DIV_EN(1), .ALU_OP_W(ALU_OP_W)) dut (
    .clk(clk), .resetn(resetn), .exe_allowin(exe_allowin),
    .id_exe_valid(id_exe_valid), .id_exe_bus(id_exe_bus), .exe_flush(exe_flush),
    .exe_mem_valid(exe_mem_valid), .mem_allowin(mem_allowin), .exe_mem_bus(exe_mem_bus),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  function automatic logic [173+ALU_OP_W-1:0] mk_bus(
      input logic gr_we, input logic mem_we, input logic rfm, input logic [1:0] msize,
      input logic [2:0] md, input logic [11:0] alu, input logic [31:0] s1, input logic [31:0] s2,
      input logic [4:0] dest, input logic [31:0] rkd);
    return {gr_we, mem_we, rfm, msize, md, alu, s1, s2, dest, rkd, 32'h0BAD_C0DE, 32'h1C00_0100};
  endfunction

  // Present one instruction for a single cycle; returns in its first EXE cycle, outputs settled.
  task automatic issue(input logic [173+ALU_OP_W-1:0] bus);
    id_exe_valid = 1'b1;
    id_exe_bus   = bus;
    @(posedge clk); #1;
    id_exe_valid = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  // Issues a divide and measures cycles from its first EXE cycle until exe_mem_valid.
  task automatic run_div(input string tag, input logic [2:0] md, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp);
    int n;
    issue(mk_bus(1'b1, 1'b0, 1'b0, 2'd2, md, 12'h000, s1, s2, 5'd9, 32'd0));
    check_val({tag, " stall"}, {31'd0, fwd_stall}, 32'd1);
    n = 0;
    while (!exe_mem_valid && n < 40) begin
      next_cycle();
      n++;
    end
    check_val({tag, " latency"}, n, 32'd33);
    check_val({tag, " result"}, exe_mem_bus[31:0], exp);
    next_cycle();
  endtask

  initial begin
    int seen;
    resetn       = 1'b0;
    id_exe_valid = 1'b0;
    id_exe_bus   = '0;
    exe_flush    = 1'b0;
    mem_allowin  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_val("rst allowin", {31'd0, exe_allowin}, 32'd1);
    check_val("rst mem_valid", {31'd0, exe_mem_valid}, 32'd0);
    check_val("rst en/we", {27'd0, data_sram_en, data_sram_we}, 32'd0);
    check_val("rst fwd", {30'd0, fwd_valid, fwd_stall}, 32'd0);
    resetn = 1'b1;
    next_cycle();

    // st.b to 0x1003
    issue(mk_bus(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, OP_ADD, 32'h1000, 32'h3, 5'd0, 32'h1234_5678));
    check_val("stb en", {31'd0, data_sram_en}, 32'd1);
    check_val("stb we", {28'd0, data_sram_we}, 32'b1000);
    check_val("stb wdata", data_sram_wdata, 32'h7878_7878);
    check_val("stb addr", data_sram_addr, 32'h1003);
    next_cycle();
    check_val("stb once", {31'd0, data_sram_en}, 32'd0);

    // st.w misaligned: all lanes, data unchanged
    issue(mk_bus(1'b0, 1'b1, 1'b0, 2'd2, 3'd0, OP_ADD, 32'h1000, 32'h1, 5'd0, 32'hCAFE_F00D));
    check_val("stw we", {28'd0, data_sram_we}, 32'b1111);
    check_val("stw wdata", data_sram_wdata, 32'hCAFE_F00D);
    next_cycle();

    // st.h held by MEM for 3 cycles
    mem_allowin = 1'b0;
    issue(mk_bus(1'b0, 1'b1, 1'b0, 2'd1, 3'd0, OP_ADD, 32'h1000, 32'h2, 5'd0, 32'hABCD_1234));
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("sth stall%0d en", i), {31'd0, data_sram_en}, 32'd0);
      check_val($sformatf("sth stall%0d allowin", i), {31'd0, exe_allowin}, 32'd0);
      next_cycle();
    end
    mem_allowin = 1'b1;
    #1;
    check_val("sth en", {31'd0, data_sram_en}, 32'd1);
    check_val("sth we", {28'd0, data_sram_we}, 32'b1100);
    check_val("sth wdata", data_sram_wdata, 32'h1234_1234);
    next_cycle();
    check_val("sth once", {31'd0, data_sram_en}, 32'd0);

    // store killed by flush in its EXE cycle
    issue(mk_bus(1'b0, 1'b1, 1'b0, 2'd2, 3'd0, OP_ADD, 32'h2000, 32'h0, 5'd0, 32'h1));
    exe_flush = 1'b1;
    #1;
    check_val("flush st en", {31'd0, data_sram_en}, 32'd0);
    next_cycle();
    exe_flush = 1'b0;
    #1;
    check_val("flush st gone", {31'd0, exe_mem_valid}, 32'd0);

    // load forwarding hazard
    mem_allowin = 1'b0;
    issue(mk_bus(1'b1, 1'b0, 1'b1, 2'd2, 3'd0, OP_ADD, 32'h2000, 32'h4, 5'd5, 32'd0));
    check_val("ld fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check_val("ld fwd_stall", {31'd0, fwd_stall}, 32'd1);
    check_val("ld fwd_dest", {27'd0, fwd_dest}, 32'd5);
    mem_allowin = 1'b1;
    #1;
    check_val("ld en/we", {27'd0, data_sram_en, data_sram_we}, 32'b10000);
    check_val("ld addr", data_sram_addr, 32'h2004);
    next_cycle();

    issue(mk_bus(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, OP_ADD, 32'd5, 32'd7, 5'd0, 32'd0));
    check_val("add r0 fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check_val("add r0 result", exe_mem_bus[31:0], 32'd12);
    next_cycle();
    issue(mk_bus(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, OP_SUB, 32'd5, 32'd7, 5'd3, 32'd0));
    check_val("sub fwd", {30'd0, fwd_valid, fwd_stall}, 32'b10);
    check_val("sub fwd_data", fwd_data, 32'hFFFF_FFFE);
    check_val("sub bus dest/off", {25'd0, exe_mem_bus[100:96], exe_mem_bus[102:101]}, {25'd0, 5'd3, 2'b10});
    next_cycle();

    run_div("div.w -7/2", 3'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("mod.w -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("div.wu 5/0", 3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_div("mod.wu 5/0", 3'd4, 32'd5, 32'd0, 32'd5);
    run_div("div.w min/-1", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("mod.w min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("div.wu 100/7", 3'd3, 32'd100, 32'd7, 32'd14);
    run_div("mod.wu 100/7", 3'd4, 32'd100, 32'd7, 32'd2);

    // flush during the 10th divide iteration
    issue(mk_bus(1'b1, 1'b0, 1'b0, 2'd2, 3'd1, 12'h000, 32'd100, 32'd7, 5'd9, 32'd0));
    repeat (10) next_cycle();
    exe_flush = 1'b1;
    #1;
    check_val("div flush mem_valid", {31'd0, exe_mem_valid}, 32'd0);
    next_cycle();
    exe_flush = 1'b0;
    #1;
    check_val("div flush allowin", {31'd0, exe_allowin}, 32'd1);
    check_val("div flush stall", {31'd0, fwd_stall}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (exe_mem_valid) seen++;
      next_cycle();
    end
    check_val("div flush no result", seen, 32'd0);
    run_div("div.w after flush", 3'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
